// File: rtl/vc_input_unit.sv
// rtl/vc_input_unit.sv - per-port eight-VC input buffer with credit tracking and arbiter handshake
module vc_input_unit #(
    parameter int FLIT_W    = 32,
    parameter int DEPTH     = 4,
    parameter int CRED_INIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2:0]        in_vc,
    input  logic [FLIT_W-1:0] in_flit,
    output logic [7:0]        req,
    input  logic [7:0]        grant,
    output logic              out_valid,
    output logic [2:0]        out_vc,
    output logic [FLIT_W-1:0] out_flit,
    input  logic              credit_in_valid,
    input  logic [2:0]        credit_in_vc,
    output logic              credit_out_valid,
    output logic [2:0]        credit_out_vc,
    output logic [1:0]        err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(CRED_INIT + 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [RW-1:0] CRED_MAX = RW'(CRED_INIT);

    logic [FLIT_W-1:0] mem_q [8][DEPTH];
    logic [FLIT_W-1:0] mem_d [8][DEPTH];
    logic [PW-1:0]     wr_ptr_q [8];
    logic [PW-1:0]     wr_ptr_d [8];
    logic [PW-1:0]     rd_ptr_q [8];
    logic [PW-1:0]     rd_ptr_d [8];
    logic [CW-1:0]     count_q  [8];
    logic [CW-1:0]     count_d  [8];
    logic [RW-1:0]     cred_q   [8];
    logic [RW-1:0]     cred_d   [8];

    logic              out_valid_q, out_valid_d;
    logic [2:0]        out_vc_q, out_vc_d;
    logic [FLIT_W-1:0] out_flit_q, out_flit_d;
    logic              credit_out_valid_q, credit_out_valid_d;
    logic [2:0]        credit_out_vc_q, credit_out_vc_d;
    logic [1:0]        err_q, err_d;

    logic              gnt_legal;
    logic [2:0]        gnt_idx;
    logic [7:0]        pop, wr_hit, wr_acc, cr_hit;

    // Request depends on registered occupancy and credit only, so grant never loops back into req
    always_comb begin
        for (int v = 0; v < 8; v++) begin
            req[v] = (count_q[v] != '0) && (cred_q[v] != '0);
        end
    end

    // A grant is legal only when exactly one bit is set and that VC is requesting
    always_comb begin
        gnt_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (grant[i]) gnt_idx = 3'(i);
        end
        gnt_legal = (grant != 8'd0) && ((grant & (grant - 8'd1)) == 8'd0) && ((grant & req) == grant);
    end

    // Per-VC next state: FIFO write/pop, credit accounting, sticky error flags, output registers
    always_comb begin
        mem_d              = mem_q;
        wr_ptr_d           = wr_ptr_q;
        rd_ptr_d           = rd_ptr_q;
        count_d            = count_q;
        cred_d             = cred_q;
        err_d              = err_q;
        out_valid_d        = gnt_legal;
        out_vc_d           = out_vc_q;
        out_flit_d         = out_flit_q;
        credit_out_valid_d = gnt_legal;
        credit_out_vc_d    = credit_out_vc_q;
        pop                = '0;
        wr_hit             = '0;
        wr_acc             = '0;
        cr_hit             = '0;

        if ((grant != 8'd0) && !gnt_legal) err_d[1] = 1'b1;

        if (gnt_legal) begin
            // Read from the registered array: a same-cycle write never bypasses to the output
            out_flit_d      = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
            out_vc_d        = gnt_idx;
            credit_out_vc_d = gnt_idx;
        end

        for (int v = 0; v < 8; v++) begin
            pop[v]    = gnt_legal && (gnt_idx == 3'(v));
            wr_hit[v] = in_valid && (in_vc == 3'(v));
            cr_hit[v] = credit_in_valid && (credit_in_vc == 3'(v));
            wr_acc[v] = wr_hit[v] && ((count_q[v] != FULL) || pop[v]);

            if (wr_hit[v] && !wr_acc[v]) err_d[0] = 1'b1;
            if (wr_acc[v]) begin
                mem_d[v][wr_ptr_q[v]] = in_flit;
                wr_ptr_d[v]           = wr_ptr_q[v] + PW'(1);
            end
            if (pop[v]) rd_ptr_d[v] = rd_ptr_q[v] + PW'(1);

            if (wr_acc[v] && !pop[v])      count_d[v] = count_q[v] + CW'(1);
            else if (!wr_acc[v] && pop[v]) count_d[v] = count_q[v] - CW'(1);

            if (pop[v] && !cr_hit[v]) begin
                cred_d[v] = cred_q[v] - RW'(1);
            end else if (cr_hit[v] && !pop[v]) begin
                if (cred_q[v] == CRED_MAX) err_d[1] = 1'b1;
                else                       cred_d[v] = cred_q[v] + RW'(1);
            end
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < 8; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
                cred_q[v]   <= CRED_MAX;
            end
            out_valid_q        <= 1'b0;
            out_vc_q           <= 3'd0;
            out_flit_q         <= '0;
            credit_out_valid_q <= 1'b0;
            credit_out_vc_q    <= 3'd0;
            err_q              <= 2'b00;
        end else begin
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            count_q            <= count_d;
            cred_q             <= cred_d;
            out_valid_q        <= out_valid_d;
            out_vc_q           <= out_vc_d;
            out_flit_q         <= out_flit_d;
            credit_out_valid_q <= credit_out_valid_d;
            credit_out_vc_q    <= credit_out_vc_d;
            err_q              <= err_d;
        end
    end

    // Flit storage needs no reset; reset clears the pointers that qualify it
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid        = out_valid_q;
    assign out_vc           = out_vc_q;
    assign out_flit         = out_flit_q;
    assign credit_out_valid = credit_out_valid_q;
    assign credit_out_vc    = credit_out_vc_q;
    assign err              = err_q;
endmodule

// File: tb/tb_vc_input_unit.sv
// tb/tb_vc_input_unit.sv - directed self-checking bench for vc_input_unit
module tb_vc_input_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_vc;
    logic [31:0] in_flit;
    logic [7:0]  req;
    logic [7:0]  grant;
    logic        out_valid;
    logic [2:0]  out_vc;
    logic [31:0] out_flit;
    logic        credit_in_valid;
    logic [2:0]  credit_in_vc;
    logic        credit_out_valid;
    logic [2:0]  credit_out_vc;
    logic [1:0]  err;

    int total = 0;
    int bad   = 0;

    vc_input_unit #(.FLIT_W(32), .DEPTH(4), .CRED_INIT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
        .req(req), .grant(grant),
        .out_valid(out_valid), .out_vc(out_vc), .out_flit(out_flit),
        .credit_in_valid(credit_in_valid), .credit_in_vc(credit_in_vc),
        .credit_out_valid(credit_out_valid), .credit_out_vc(credit_out_vc),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] vc, input logic [31:0] d);
        in_valid = 1'b1; in_vc = vc; in_flit = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop(input logic [7:0] g);
        grant = g;
        tick();
        grant = 8'd0;
    endtask

    task automatic cred(input logic [2:0] vc);
        credit_in_valid = 1'b1; credit_in_vc = vc;
        tick();
        credit_in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vc = 3'd0; in_flit = 32'd0;
        grant = 8'd0; credit_in_valid = 1'b0; credit_in_vc = 3'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_req", req, 8'h00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_flit", out_flit, 32'd0);
        chk("rst_credit_out_valid", credit_out_valid, 1'b0);
        chk("rst_err", err, 2'b00);

        // single flit on VC3
        wr(3'd3, 32'hA5A5_0001);
        chk("vc3_req", req, 8'h08);
        pop(8'h08);
        chk("vc3_out_valid", out_valid, 1'b1);
        chk("vc3_out_vc", out_vc, 3'd3);
        chk("vc3_out_flit", out_flit, 32'hA5A5_0001);
        chk("vc3_cred_valid", credit_out_valid, 1'b1);
        chk("vc3_cred_vc", credit_out_vc, 3'd3);
        chk("vc3_req_after", req, 8'h00);
        tick();
        chk("vc3_out_valid_drop", out_valid, 1'b0);
        chk("vc3_cred_valid_drop", credit_out_valid, 1'b0);

        // VC0: four flits, credits run out together with the FIFO
        for (int i = 1; i <= 4; i++) wr(3'd0, 32'(i));
        chk("vc0_req_full", req, 8'h01);
        for (int i = 1; i <= 4; i++) begin
            grant = 8'h01;
            tick();
            chk("vc0_out_valid", out_valid, 1'b1);
            chk("vc0_out_flit", out_flit, 64'(i));
        end
        grant = 8'd0;
        chk("vc0_req_empty", req, 8'h00);
        chk("vc0_err", err, 2'b00);

        // VC1: overflow on the fifth write
        for (int i = 1; i <= 5; i++) wr(3'd1, 32'h10 + 32'(i));
        chk("vc1_overflow_err", err, 2'b01);
        chk("vc1_req", req, 8'h02);
        for (int i = 1; i <= 4; i++) begin
            pop(8'h02);
            chk("vc1_out_flit", out_flit, 64'h10 + 64'(i));
        end
        chk("vc1_req_empty", req, 8'h00);
        tick();
        chk("vc1_no_fifth", out_valid, 1'b0);

        // VC2: writes to a full VC accepted while popping; credit gating
        for (int i = 1; i <= 4; i++) wr(3'd2, 32'h20 + 32'(i));
        for (int i = 1; i <= 4; i++) begin
            grant = 8'h04;
            in_valid = (i <= 2); in_vc = 3'd2; in_flit = 32'h24 + 32'(i);
            tick();
            chk("vc2_out_flit", out_flit, 64'h20 + 64'(i));
        end
        grant = 8'd0; in_valid = 1'b0;
        chk("vc2_req_no_cred", req, 8'h00);
        chk("vc2_err_unchanged", err, 2'b01);
        cred(3'd2);
        chk("vc2_req_cred_back", req, 8'h04);
        grant = 8'h04; credit_in_valid = 1'b1; credit_in_vc = 3'd2;
        tick();
        grant = 8'd0; credit_in_valid = 1'b0;
        chk("vc2_pop_cred_flit", out_flit, 32'h25);
        chk("vc2_pop_cred_req", req, 8'h04);
        pop(8'h04);
        chk("vc2_last_flit", out_flit, 32'h26);
        chk("vc2_req_done", req, 8'h00);
        chk("vc2_err_final", err, 2'b01);

        // illegal multi-hot grant
        cred(3'd0);
        cred(3'd1);
        wr(3'd0, 32'h31);
        wr(3'd1, 32'h41);
        chk("illegal_req_pre", req, 8'h03);
        pop(8'h03);
        chk("illegal_out_valid", out_valid, 1'b0);
        chk("illegal_err", err, 2'b11);
        chk("illegal_req_kept", req, 8'h03);
        pop(8'h01);
        chk("illegal_after_vc0", out_flit, 32'h31);
        pop(8'h02);
        chk("illegal_after_vc1", out_flit, 32'h41);
        chk("illegal_req_clear", req, 8'h00);

        // VC5: spurious credit return must not raise the credit above its reset value
        cred(3'd5);
        chk("vc5_err_sticky", err, 2'b11);
        for (int i = 1; i <= 4; i++) wr(3'd5, 32'h50 + 32'(i));
        for (int i = 1; i <= 4; i++) pop(8'h20);
        chk("vc5_last_flit", out_flit, 32'h54);
        wr(3'd5, 32'h55);
        chk("vc5_cred_capped", req, 8'h00);

        // VC6: reset mid-stream discards flits and errors
        wr(3'd6, 32'h61);
        wr(3'd6, 32'h62);
        rst = 1'b1; grant = 8'h40;
        tick();
        rst = 1'b0; grant = 8'd0;
        chk("rst2_out_valid", out_valid, 1'b0);
        chk("rst2_req", req, 8'h00);
        chk("rst2_err", err, 2'b00);
        wr(3'd6, 32'h71);
        chk("vc6_req", req, 8'h40);
        pop(8'h40);
        chk("vc6_out_flit", out_flit, 32'h71);
        chk("vc6_out_vc", out_vc, 3'd6);
        tick();
        chk("vc6_req_empty", req, 8'h00);
        chk("vc6_out_valid_drop", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vc_input_unit.md
# vc_input_unit

Per-input-port virtual-channel buffer for the non-pipelined VC router, sitting directly upstream of the 8-way round-robin switch arbiter. Stores incoming flits in eight per-VC FIFOs, tracks downstream credits per VC, and raises one request bit per VC that holds a flit and has a credit. It consumes the arbiter's one-hot grant to dequeue the winning flit onto the crossbar, and returns a credit upstream for each dequeue.

## Interface
- FLIT_W, 32, flit payload width
- DEPTH, 4, flit slots per VC FIFO (power of two, ≥2)
- CRED_INIT, 4, downstream buffer slots per VC; per-VC credit counter reset value (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  flit write strobe from upstream link
- in_vc  in  3  target VC of incoming flit
- in_flit  in  FLIT_W  incoming flit
- req  out  8  per-VC request to switch arbiter
- grant  in  8  arbiter grant, expected one-hot or zero
- out_valid  out  1  registered: flit on out_flit valid this cycle
- out_vc  out  3  registered: VC of out_flit
- out_flit  out  FLIT_W  registered dequeued flit, to crossbar
- credit_in_valid  in  1  downstream returned one credit
- credit_in_vc  in  3  VC of returned credit
- credit_out_valid  out  1  registered: one slot freed, to upstream
- credit_out_vc  out  3  registered: VC of freed slot
- err  out  2  sticky: [0] FIFO overflow, [1] credit/grant protocol violation

## Operation
- Per VC v: circular FIFO (wr_ptr, rd_ptr, count 0..DEPTH) and credit counter cred[v] (0..CRED_INIT).
- req[v] = (count[v] != 0) & (cred[v] != 0); combinational from registers only, no path from grant or in_* inputs.
- Write: in_valid writes in_flit into FIFO in_vc at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
- Write to full VC: dropped unless the same VC is popped in the same cycle (then accepted, count stays DEPTH); dropped write sets err[0].
- Pop: grant legal if exactly one bit set at index g with req[g]=1. Legal grant pops FIFO g (rd_ptr wraps), decrements cred[g], loads out_flit/out_vc=g, out_valid=1, credit_out_vc=g, credit_out_valid=1.
- Illegal grant (multi-hot, or bit on VC with req low): no pop, no credit change, out_valid=0, err[1] set. grant=0: nothing, no error.
- Simultaneous write and pop on the same VC: count unchanged; write to empty VC never bypasses to output.
- Credit return: credit_in_valid increments cred[credit_in_vc]. Same-cycle pop and return on same VC: cred unchanged. Return when cred already CRED_INIT and no same-VC pop: ignored, err[1] set.
- Events on different VCs are fully independent in the same cycle.
- err bits clear only on rst.

## Timing
- Reset (rst high at edge): all count=0, pointers=0, cred=CRED_INIT, out_valid=0, out_vc=0, out_flit=0, credit_out_valid=0, credit_out_vc=0, err=0; req=0 the cycle after. rst mid-operation discards all buffered flits and outstanding credit state; in_valid/grant/credit_in ignored in a reset cycle.
- Write at edge t -> req[v] high from t (after edge) if credit available: 1-cycle write-to-request latency.
- Grant sampled at edge t -> out_valid, out_flit, credit_out_* valid for the one cycle after edge t; they deassert next cycle unless another legal grant.
- req reflects post-pop state the cycle after a grant; last flit popped -> req[v] low next cycle, no spurious second grant possible.
- Credit return at edge t -> req may rise after edge t.
- Sustained throughput: one flit per cycle per port.

## Test plan
- Reset then write 0xA5A5_0001 to VC3 -> next cycle req=8'h08; grant=8'h08 -> next cycle out_valid=1, out_vc=3, out_flit=0xA5A5_0001, credit_out_valid=1, credit_out_vc=3; req=0 after.
- Write 4 flits 1..4 to VC0, hold grant=8'h01 each cycle req[0]=1 -> flits emerge in order 1,2,3,4; cred[0] reaches 0 so req[0] low with 0 flits left; err=0.
- Write 5 flits to VC1 (DEPTH=4) with no grant -> 5th dropped, err[0]=1; four pops return flits 1..4 only.
- CRED_INIT=4, 6 flits on VC2 over two writes: after 4 grants req[2]=0 with 2 flits buffered; credit_in_valid on VC2 -> req[2]=1 next cycle; same-cycle pop+credit on VC2 keeps req[2]=1.
- grant=8'h03 with req=8'h03 -> no pop, out_valid=0, err[1]=1; credit return on VC5 with cred full -> err[1] stays 1, cred unchanged.
- Fill VC6 with 2 flits, assert rst mid-stream with grant=8'h40 -> out_valid=0, req=0, err=0 after reset; subsequent write/grant on VC6 returns only new data.
